ram_fifo_1clk: RTL and testbench
================================

# ram_fifo_1clk

Single-clock valid/ready FIFO that stores its payload in a `ram_wrap_1r1w` instance and hides that RAM's one-cycle read latency behind a two-entry output prefetch buffer. It sits between MSM pipeline stages that produce and consume point/bucket words in bursts. Both sides sustain one word per cycle with no combinational path from `out_ready` to `in_ready`.

## Interface
- `DEPTH`, 1024: RAM words; power of two, ≥4.
- `WIDTH`, 32: payload width in bits.
- `ADDRSZ`, 10: log2(DEPTH).
- `CNTSZ`, 11: width of `count`; must hold DEPTH+2.
- `RAM_STYLE`, "block": passed to the RAM as `FPGA_RAM_STYLE`.

- `clk`  in  1  single clock; drives both `wclk` and `rclk` of the RAM.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  FIFO accepts a word; push = `in_valid & in_ready`.
- `in_data`  in  WIDTH  pushed word.
- `out_valid`  out  1  head word present on `out_data`.
- `out_ready`  in  1  consumer takes the word; pop = `out_valid & out_ready`.
- `out_data`  out  WIDTH  head word; stable while `out_valid & !out_ready`.
- `count`  out  CNTSZ  total words held = RAM words + in-flight read + buffered words.
- `full`  out  1  `count == DEPTH+2`.
- `empty`  out  1  `count == 0`.

## Operation
- Storage has three parts:
  - RAM, indexed by `wptr`/`rptr` (ADDRSZ bits, natural wrap).
  - A read in flight, `rd_pend`.
  - Output buffer `ob[0..1]` with occupancy `ob_cnt` (0..2). `ob[0]` is the head.
- Capacity is DEPTH+2.
- Push:
  - RAM `we=1`, `waddr=wptr`, `wem` all ones.
  - `wptr++`, `ram_cnt++`.
  - `in_ready = (ram_cnt != DEPTH)` and `!rst`. It is registered-state only.
- Prefetch:
  - Issue `re=1`, `raddr=rptr`, then `rptr++`, `ram_cnt--`.
  - Condition: `ram_cnt != 0` and `ob_cnt + rd_pend - pop < 2`.
- Read data arrives the cycle after `re`. It is written into `ob[ob_cnt - pop]`.
- Pop: `ob[0] <= ob[1]`, `ob_cnt--`. Pop and arrival in the same cycle are both applied.
- Ordering: words emerge strictly in push order.
- Bypass: none. Prefetch reads only addresses written on an earlier edge, because `ram_cnt` counts committed writes. RAM read-during-write behaviour is never exercised.
- Simultaneous events:
  - Push, prefetch and pop may all occur in one cycle.
  - `ram_cnt` and `count` update by the net change.
  - Push at `ram_cnt==DEPTH` is impossible because `in_ready=0`.
  - A same-cycle prefetch does not make `in_ready` rise until the next cycle.
- Reset mid-operation: all contents are discarded.
  - Pointers, `ram_cnt`, `rd_pend` and `ob_cnt` are cleared.
  - A read completing on the reset edge is dropped.
  - RAM contents are left untouched.

## Timing
- Reset values (during and after `rst`): `out_valid=0`, `count=0`, `empty=1`, `full=0`, `in_ready=0`. `in_ready` is 1 the first cycle after `rst` deasserts.
- `out_data` is don't-care while `out_valid=0`.
- Empty-to-output latency:
  - Push on edge T: RAM write.
  - `re` during cycle T+1.
  - Data captured on edge T+2.
  - `out_valid=1` in cycle T+2, so 2 cycles.
- Throughput: one push and one pop per cycle indefinitely once `ob_cnt ≥ 1`.
- `count`, `full`, `empty` are registered and reflect all events of the previous edge.
- RAM is configured with FLOPOUT=0 and HOLD_DATA_OUT=1, giving fixed 1-cycle read latency.

## Structure
- Shared package/header `msm_fifo_pkg` holds:
  - The `clog2` function.
  - The rule `CNTSZ = clog2(DEPTH+3)`.
  - The prefetch-buffer depth constant `FIFO_OB_DEPTH = 2`.
- Sub-module `ram_wrap_1r1w` is the storage. Tie `wclk=rclk=clk` and `WESZ=1`.
- Sub-module `fifo_ob2` is the natural split: the 2-entry output buffer with arrival/pop/occupancy logic. It sits beside the pointer/count controller in the top level.

## Test plan
- Reset then idle: `in_ready=1`, `out_valid=0`, `count=0`, `empty=1` → stays so for 20 cycles.
- Single push of 0xA5A5_0001 at edge T:
  - `out_valid` rises at cycle T+2 with `out_data=0xA5A5_0001`.
  - Pop → `empty=1` next cycle.
- Streaming, DEPTH=16, 1000 words, `out_ready=1`, incrementing data:
  - One word out per cycle after the 2-cycle fill, in order.
  - `count` ≤ 3 throughout.
- Fill to capacity, DEPTH=16, `out_ready=0`:
  - 18 pushes accepted, then `in_ready=0` and `full=1`, `count=18`.
  - Drain yields 0..17 in order.
- Random `in_valid`/`out_ready` (50%) over 10k words: scoreboard matches in order; `out_data` stable while stalled.
- Reset asserted with `count=10` and a read in flight: next cycle `count=0`, `out_valid=0`. A subsequent push of 0x7 emerges as the first word.

Source files
------------

// File: rtl/msm_fifo_pkg.sv
// Shared constants and helpers for the MSM FIFO family.
package msm_fifo_pkg;

    // Number of prefetch slots sitting behind the RAM read port.
    localparam int FIFO_OB_DEPTH = 32'sd2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int v;
        int r;
        v = value - 32'sd1;
        r = 32'sd0;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 1;
        end
        return r;
    endfunction

    // Width needed for a FIFO occupancy counter: it must reach DEPTH + FIFO_OB_DEPTH.
    function automatic int fifo_cntsz(input int depth);
        return clog2(depth + 32'sd3);
    endfunction

    // Width of the prefetch-buffer occupancy counter (0..FIFO_OB_DEPTH).
    localparam int FIFO_OB_CSZ = clog2(FIFO_OB_DEPTH + 32'sd1);

endpackage

// File: rtl/fifo_ob2.sv
// Two-entry output buffer that absorbs RAM read data and presents the FIFO head.
// An arriving word lands in the slot just behind whatever survives this
// cycle's pop, so pop and arrival in the same cycle are both honoured.
module fifo_ob2
    import msm_fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   arr_valid,
    input  logic [WIDTH-1:0]       arr_data,
    input  logic                   pop,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [FIFO_OB_CSZ-1:0] ob_cnt
);

    logic [WIDTH-1:0]       ob_r     [FIFO_OB_DEPTH];
    logic [WIDTH-1:0]       ob_nxt_s [FIFO_OB_DEPTH];
    logic [FIFO_OB_CSZ-1:0] cnt_r;
    logic [FIFO_OB_CSZ-1:0] cnt_nxt_s;
    logic [FIFO_OB_CSZ-1:0] wr_idx_s;
    logic                   valid_r;

    // Next buffer contents: shift on pop, then place the arriving word.
    always_comb begin
        ob_nxt_s  = ob_r;
        wr_idx_s  = cnt_r - {{(FIFO_OB_CSZ-1){1'b0}}, pop};
        cnt_nxt_s = wr_idx_s + {{(FIFO_OB_CSZ-1){1'b0}}, arr_valid};
        if (pop) begin
            ob_nxt_s[0] = ob_r[1];
        end else begin
            ob_nxt_s[0] = ob_r[0];
        end
        if (arr_valid) begin
            case (wr_idx_s)
                2'd0:    ob_nxt_s[0] = arr_data;
                2'd1:    ob_nxt_s[1] = arr_data;
                default: ob_nxt_s[1] = ob_nxt_s[1];
            endcase
        end else begin
            ob_nxt_s[1] = ob_nxt_s[1];
        end
    end

    // Buffer state; reset drops any word arriving on the reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= {FIFO_OB_CSZ{1'b0}};
            valid_r <= 1'b0;
            for (int i = 0; i < FIFO_OB_DEPTH; i++) begin
                ob_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            cnt_r   <= cnt_nxt_s;
            valid_r <= (cnt_nxt_s != {FIFO_OB_CSZ{1'b0}});
            ob_r    <= ob_nxt_s;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = ob_r[0];
    assign ob_cnt    = cnt_r;

endmodule

// File: rtl/ram_wrap_1r1w.sv
// Simple dual-port RAM wrapper: one write port with lane mask, one read port.
// FLOPOUT adds an extra output register; HOLD_DATA_OUT keeps rdata stable
// between reads instead of clearing it.
module ram_wrap_1r1w #(
    parameter int    DEPTH          = 1024,
    parameter int    WIDTH          = 32,
    parameter int    ADDRSZ         = 10,
    parameter int    WESZ           = 1,
    parameter int    FLOPOUT        = 0,
    parameter int    HOLD_DATA_OUT  = 1,
    parameter string FPGA_RAM_STYLE = "block"
) (
    input  logic              wclk,
    input  logic              we,
    input  logic [ADDRSZ-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [WESZ-1:0]   wem,
    input  logic              rclk,
    input  logic              re,
    input  logic [ADDRSZ-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int LANE_W = WIDTH / WESZ;

    (* ram_style = FPGA_RAM_STYLE *)
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rd_r;

    // Masked write of the selected lanes.
    always_ff @(posedge wclk) begin
        if (we) begin
            for (int l = 0; l < WESZ; l++) begin
                if (wem[l]) begin
                    mem_r[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Registered read; output either holds or clears when no read is issued.
    always_ff @(posedge rclk) begin
        if (re) begin
            rd_r <= mem_r[raddr];
        end else if (HOLD_DATA_OUT == 0) begin
            rd_r <= {WIDTH{1'b0}};
        end
    end

    generate
        if (FLOPOUT != 0) begin : g_flopout
            logic [WIDTH-1:0] rd2_r;
            // Optional second output stage for timing closure.
            always_ff @(posedge rclk) begin
                rd2_r <= rd_r;
            end
            assign rdata = rd2_r;
        end else begin : g_direct
            assign rdata = rd_r;
        end
    endgenerate

endmodule

// File: rtl/ram_fifo_1clk.sv
// Single-clock valid/ready FIFO backed by a 1R1W RAM with a 2-word prefetch
// buffer hiding the RAM read latency. in_ready depends only on registered
// state (and reset), never on out_ready.
module ram_fifo_1clk
    import msm_fifo_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter int    WIDTH     = 32,
    parameter int    ADDRSZ    = 10,
    parameter int    CNTSZ     = 11,
    parameter string RAM_STYLE = "block"
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTSZ-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDRSZ:0]  RAM_FULL = (ADDRSZ+1)'(DEPTH);
    localparam logic [CNTSZ-1:0] CAPACITY = CNTSZ'(DEPTH + FIFO_OB_DEPTH);
    localparam logic [2:0]       OB_LIM   = 3'(FIFO_OB_DEPTH);

    logic [ADDRSZ-1:0]      wptr_r;
    logic [ADDRSZ-1:0]      rptr_r;
    logic [ADDRSZ:0]        ram_cnt_r;
    logic [ADDRSZ:0]        ram_cnt_nxt_s;
    logic                   rd_pend_r;
    logic [CNTSZ-1:0]       count_r;
    logic [CNTSZ-1:0]       count_nxt_s;
    logic                   full_r;
    logic                   empty_r;
    logic                   push_s;
    logic                   pop_s;
    logic                   pf_s;
    logic                   ob_valid_s;
    logic [FIFO_OB_CSZ-1:0] ob_cnt_s;
    logic [WIDTH-1:0]       ram_rdata_s;

    assign in_ready = !rst && (ram_cnt_r != RAM_FULL);
    assign push_s   = in_valid && in_ready;
    assign pop_s    = ob_valid_s && out_ready;

    // Prefetch whenever the RAM holds committed words and the buffer plus the
    // read in flight, net of this cycle's pop, leaves a free slot.
    always_comb begin
        pf_s = 1'b0;
        if ((ram_cnt_r != {(ADDRSZ+1){1'b0}}) &&
            (({1'b0, ob_cnt_s} + {2'b00, rd_pend_r}) < (OB_LIM + {2'b00, pop_s}))) begin
            pf_s = 1'b1;
        end else begin
            pf_s = 1'b0;
        end
    end

    // Net occupancy changes for the RAM region and the whole FIFO.
    always_comb begin
        ram_cnt_nxt_s = ram_cnt_r + {{ADDRSZ{1'b0}}, push_s} - {{ADDRSZ{1'b0}}, pf_s};
        count_nxt_s   = count_r + {{(CNTSZ-1){1'b0}}, push_s} - {{(CNTSZ-1){1'b0}}, pop_s};
    end

    // Pointer, read-in-flight and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r    <= {ADDRSZ{1'b0}};
            rptr_r    <= {ADDRSZ{1'b0}};
            ram_cnt_r <= {(ADDRSZ+1){1'b0}};
            rd_pend_r <= 1'b0;
            count_r   <= {CNTSZ{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
        end else begin
            wptr_r    <= wptr_r + {{(ADDRSZ-1){1'b0}}, push_s};
            rptr_r    <= rptr_r + {{(ADDRSZ-1){1'b0}}, pf_s};
            ram_cnt_r <= ram_cnt_nxt_s;
            rd_pend_r <= pf_s;
            count_r   <= count_nxt_s;
            full_r    <= (count_nxt_s == CAPACITY);
            empty_r   <= (count_nxt_s == {CNTSZ{1'b0}});
        end
    end

    ram_wrap_1r1w #(
        .DEPTH          (DEPTH),
        .WIDTH          (WIDTH),
        .ADDRSZ         (ADDRSZ),
        .WESZ           (1),
        .FLOPOUT        (0),
        .HOLD_DATA_OUT  (1),
        .FPGA_RAM_STYLE (RAM_STYLE)
    ) u_ram (
        .wclk  (clk),
        .we    (push_s),
        .waddr (wptr_r),
        .wdata (in_data),
        .wem   (1'b1),
        .rclk  (clk),
        .re    (pf_s),
        .raddr (rptr_r),
        .rdata (ram_rdata_s)
    );

    fifo_ob2 #(
        .WIDTH (WIDTH)
    ) u_ob (
        .clk       (clk),
        .rst       (rst),
        .arr_valid (rd_pend_r),
        .arr_data  (ram_rdata_s),
        .pop       (pop_s),
        .out_valid (ob_valid_s),
        .out_data  (out_data),
        .ob_cnt    (ob_cnt_s)
    );

    assign out_valid = ob_valid_s;
    assign count     = count_r;
    assign full      = full_r;
    assign empty     = empty_r;

endmodule

// File: tb/tb_ram_fifo_1clk.sv
// Self-checking bench for ram_fifo_1clk (DEPTH=16). The reference is a queue
// of words plus the edge on which each was pushed: a word is visible at the
// head two edges after its push, count is the queue size.
module tb_ram_fifo_1clk;

    localparam int DEPTH  = 16;
    localparam int WIDTH  = 32;
    localparam int ADDRSZ = 4;
    localparam int CNTSZ  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNTSZ-1:0] count;
    logic             full;
    logic             empty;

    int               n_pass  = 0;
    int               n_total = 0;
    int               cyc     = 0;
    logic [WIDTH-1:0] mdl_q[$];
    int               stamp_q[$];
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data  = '0;

    ram_fifo_1clk #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .ADDRSZ    (ADDRSZ),
        .CNTSZ     (CNTSZ),
        .RAM_STYLE ("block")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Compare all outputs with the reference at the falling edge.
    task automatic check_outputs();
        int sz;
        logic exp_ov;
        sz = mdl_q.size();
        exp_ov = (sz > 0) ? ((cyc - stamp_q[0]) >= 2) : 1'b0;
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == DEPTH + 2));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) chk("out_data", 64'(out_data), 64'(mdl_q[0]));
        if (rst) chk("in_ready_rst", 64'(in_ready), 64'd0);
        else if (sz < DEPTH) chk("in_ready", 64'(in_ready), 64'd1);
        else if (sz == DEPTH + 2) chk("in_ready_full", 64'(in_ready), 64'd0);
        if (prev_stall && out_valid) chk("stall_stable", 64'(out_data), 64'(prev_data));
    endtask

    // One clock: drive at negedge, update reference at posedge, check at next negedge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                        input logic r, output logic acc);
        logic ir;
        logic ov;
        logic [WIDTH-1:0] od;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        rst       = r;
        #1;
        ir = in_ready;
        ov = out_valid;
        od = out_data;
        acc = iv && ir && !r;
        @(posedge clk);
        cyc++;
        if (r) begin
            mdl_q.delete();
            stamp_q.delete();
        end else begin
            if (ov && ordy && mdl_q.size() > 0) begin
                void'(mdl_q.pop_front());
                void'(stamp_q.pop_front());
            end
            if (acc) begin
                mdl_q.push_back(d);
                stamp_q.push_back(cyc);
            end
        end
        prev_stall = ov && !ordy && !r;
        prev_data  = od;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 60 && (mdl_q.size() > 0 || out_valid); i++) begin
            step(1'b0, '0, 1'b1, 1'b0, acc);
        end
        chk("drain_done", 64'(mdl_q.size()), 64'd0);
    endtask

    initial begin
        logic acc;
        logic [WIDTH-1:0] dv;
        int pushed;
        int guard;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; rst = 1'b1;
        @(negedge clk);

        // Reset, then idle.
        repeat (3) step(1'b0, '0, 1'b0, 1'b1, acc);
        repeat (20) step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Single word: visible two edges after the push, then popped.
        step(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, acc);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("single_not_yet", 64'(out_valid), 64'd0);
        step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("single_data", 64'(out_data), 64'hA5A5_0001);
        step(1'b0, '0, 1'b1, 1'b0, acc);
        chk("single_empty", 64'(empty), 64'd1);

        // Streaming 1000 incrementing words with the consumer always ready.
        dv = 32'd0;
        for (int i = 0; i < 1000; i++) begin
            step(1'b1, dv, 1'b1, 1'b0, acc);
            if (acc) dv = dv + 32'd1;
            chk("stream_cnt_le3", 64'(count <= 5'd3), 64'd1);
        end
        chk("stream_all_taken", 64'(dv), 64'd1000);
        drain();

        // Fill to capacity with the consumer stalled.
        dv = 32'd0;
        for (int i = 0; i < 25; i++) begin
            step(1'b1, dv, 1'b0, 1'b0, acc);
            if (acc) dv = dv + 32'd1;
        end
        chk("fill_accepted", 64'(dv), 64'd18);
        chk("fill_count", 64'(count), 64'd18);
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        drain();

        // Random valid/ready over 10k words.
        pushed = 0;
        guard  = 0;
        dv = 32'd0;
        while (pushed < 10000 && guard < 60000) begin
            step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0, acc);
            if (acc) pushed++;
            guard++;
        end
        chk("random_done", 64'(pushed), 64'd10000);
        drain();

        // Reset while holding 10 words with a read in flight.
        for (int i = 0; i < 10; i++) step(1'b1, 32'(i + 100), 1'b0, 1'b0, acc);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("pre_rst_count", 64'(count), 64'd10);
        step(1'b1, 32'hBEEF, 1'b1, 1'b0, acc);
        chk("pre_rst_count2", 64'(count), 64'd10);
        step(1'b0, '0, 1'b0, 1'b1, acc);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        step(1'b1, 32'h7, 1'b0, 1'b0, acc);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, acc);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_head", 64'(out_data), 64'h7);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
